sensor_conditioner: RTL
=======================

SENSOR_CONDITIONER -- requirements
Module: sensor_conditioner

Interface
REQ-001 Parameter DEBOUNCE, default 4: the number of consecutive synchronized cycles a raw level must hold before it is accepted. Legal range is 2..15.
REQ-002 Parameter REJ_W, default 4: the width of the rejected-event counter.
REQ-003 clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 reset  input  1  reset; synchronous, active-high.
REQ-005 rawBack  input  1  back (entry) beam sensor, asynchronous; 1 = beam blocked.
REQ-006 rawFront  input  1  front (exit) beam sensor, asynchronous; 1 = beam blocked.
REQ-007 fullFlag  input  1  queue-full indication from the queue manager.
REQ-008 emptyFlag  input  1  queue-empty indication from the queue manager.
REQ-009 upSignal  output  1  registered one-cycle pulse: one person entered the queue.
REQ-010 downSignal  output  1  registered one-cycle pulse: one person left the queue.
REQ-011 rejCount  output  REJ_W  saturating count of events suppressed by gating.

Function
REQ-012 Each raw input SHALL pass through a two-flop synchronizer whose flops reset to 0.
REQ-013 Each channel SHALL hold a debounced level lvl (reset 0) and a counter cnt (reset 0).
- If the synchronized sample equals lvl: cnt <= 0.
- If it differs and cnt == DEBOUNCE-1: lvl <= sample, cnt <= 0.
- Otherwise: cnt <= cnt+1.
REQ-014 Any synchronized excursion shorter than DEBOUNCE cycles SHALL leave lvl unchanged and produce no event.
REQ-015 A channel event SHALL be the 1->0 transition of its lvl, meaning the person has fully passed the beam. The 0->1 transition SHALL produce no event.
REQ-016 Latency: raw input changes before edge 1 and stays stable; the resulting pulse SHALL be high in the cycle following edge DEBOUNCE+3 and low again after edge DEBOUNCE+4.
REQ-017 The back channel SHALL map to upSignal and the front channel to downSignal. Each pulse SHALL be exactly one cycle wide per event.
REQ-018 upSignal and downSignal SHALL never be 1 in the same cycle.
REQ-019 Simultaneous events: if both channel events occur in the same cycle, the down event SHALL be issued in that cycle. The up event SHALL be held in a one-deep pending register and issued in the next cycle.
REQ-020 Gating SHALL be evaluated in the cycle an event is issued, using fullFlag and emptyFlag as sampled at that edge.
- An up event with fullFlag=1 is suppressed: upSignal stays 0.
- A down event with emptyFlag=1 is suppressed: downSignal stays 0.
REQ-021 Each suppressed event SHALL increment rejCount by 1, saturating at 2^REJ_W-1.
REQ-022 If two events are suppressed in one cycle, rejCount SHALL increase by 2, still saturating.
REQ-023 A pending up event SHALL be re-gated in the cycle it is issued, not the cycle it arrived.
REQ-024 Back-to-back up events on one channel are at least 2*DEBOUNCE cycles apart, so the pending register SHALL never overflow. No extra buffering is required.
REQ-025 fullFlag and emptyFlag SHALL NOT affect synchronizer or debounce state.

Reset
REQ-026 While reset=1 at a clock edge, the following SHALL be cleared to 0: synchronizers, lvl, cnt, the previous-level registers, the pending register, upSignal, downSignal and rejCount.
REQ-027 Reset asserted mid-debounce or with a pending event SHALL discard that event; no pulse SHALL appear after reset deasserts.
REQ-028 If a beam is still blocked when reset deasserts, it SHALL debounce to lvl=1 with no event. Its later release SHALL produce a normal event.

Verification
REQ-029 DEBOUNCE=4, flags 0: rawBack held 1 for 10 cycles, then set to 0 before edge 1 -> upSignal=1 for exactly one cycle after edge 7; rejCount=0.
REQ-030 rawFront glitches high for 3 synchronized cycles, then returns low -> no downSignal ever; lvl stays 0.
REQ-031 Both beams released in the same cycle, flags 0 -> downSignal pulses in cycle N and upSignal in cycle N+1; the two are never high together.
REQ-032 fullFlag=1: 20 back-beam release events -> upSignal never 1; rejCount ends at 15 (saturated).
REQ-033 emptyFlag=1: one front-beam release event -> downSignal stays 0 and rejCount=1. Then with emptyFlag=0, a second release -> one downSignal pulse.
REQ-034 Reset pulsed 2 cycles after a back-beam release, with DEBOUNCE not yet elapsed -> no upSignal afterwards; all outputs 0 on the cycle after reset.

Source files
------------

// File: rtl/sensor_conditioner.sv
// Beam-sensor conditioner: synchronizes and debounces the back/front beams, turns each
// beam release into a one-cycle up/down pulse, gates pulses on queue full/empty and counts rejects.
module sensor_conditioner #(
    parameter int DEBOUNCE = 4,
    parameter int REJ_W    = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             rawBack,
    input  logic             rawFront,
    input  logic             fullFlag,
    input  logic             emptyFlag,
    output logic             upSignal,
    output logic             downSignal,
    output logic [REJ_W-1:0] rejCount
);

    localparam logic [3:0]       CNT_TC  = 4'(DEBOUNCE - 1);
    localparam logic [REJ_W:0]   REJ_MAX = {1'b0, {REJ_W{1'b1}}};

    // Channel index 0 = back (entry), 1 = front (exit).
    logic [1:0]      sync1_q, sync2_q;
    logic [1:0]      lvl_q, lvl_d;
    logic [1:0]      prev_q;
    logic [1:0][3:0] cnt_q, cnt_d;
    logic            pend_q, pend_d;
    logic            up_q, up_d;
    logic            down_q, down_d;
    logic [REJ_W-1:0] rej_q, rej_d;

    logic [1:0]      evt;
    logic            up_src, up_try, down_try;
    logic [1:0]      rej_inc;
    logic [REJ_W:0]  rej_sum;

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            lvl_d[i] = lvl_q[i];
            cnt_d[i] = cnt_q[i];
            if (sync2_q[i] == lvl_q[i]) begin
                cnt_d[i] = 4'd0;
            end else if (cnt_q[i] == CNT_TC) begin
                lvl_d[i] = sync2_q[i];
                cnt_d[i] = 4'd0;
            end else begin
                cnt_d[i] = cnt_q[i] + 4'd1;
            end
        end
    end

    // An event is a falling debounced level: the person has fully cleared the beam.
    assign evt = prev_q & ~lvl_q;

    always_comb begin
        up_src   = pend_q | evt[0];
        up_try   = 1'b0;
        down_try = 1'b0;
        pend_d   = 1'b0;
        if (evt[1]) begin
            // Down wins the cycle; any up waits one cycle and is gated when it actually issues.
            down_try = 1'b1;
            pend_d   = up_src;
        end else begin
            up_try   = up_src;
        end
        up_d    = up_try & ~fullFlag;
        down_d  = down_try & ~emptyFlag;
        rej_inc = {1'b0, up_try & fullFlag} + {1'b0, down_try & emptyFlag};
        rej_sum = {1'b0, rej_q} + (REJ_W+1)'(rej_inc);
        rej_d   = (rej_sum > REJ_MAX) ? REJ_MAX[REJ_W-1:0] : rej_sum[REJ_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
            lvl_q   <= '0;
            cnt_q   <= '0;
            prev_q  <= '0;
            pend_q  <= 1'b0;
            up_q    <= 1'b0;
            down_q  <= 1'b0;
            rej_q   <= '0;
        end else begin
            sync1_q <= {rawFront, rawBack};
            sync2_q <= sync1_q;
            lvl_q   <= lvl_d;
            cnt_q   <= cnt_d;
            prev_q  <= lvl_q;
            pend_q  <= pend_d;
            up_q    <= up_d;
            down_q  <= down_d;
            rej_q   <= rej_d;
        end
    end

    assign upSignal   = up_q;
    assign downSignal = down_q;
    assign rejCount   = rej_q;

endmodule
